// File: rtl/jzjpcc_muldiv_controller.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide,
// retiring BITS_PER_CYCLE bits per CALC cycle, with 1-cycle special-case results.
module jzjpcc_muldiv_controller #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stallExecute,
  output logic        resultValid,
  output logic [31:0] result,
  output logic        busy,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = 6;

  state_t        state;
  logic [CW-1:0] count;
  logic [2:0]    op;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic          neg;

  // Handshake: an op is taken in the IDLE cycle where start=1 and flush=0;
  // execute stays stalled until the DONE cycle, where resultValid=1 for one cycle.
  assign stallExecute = ~reset & (((state == IDLE) & start & ~flush) | (state == CALC));
  assign busy         = (state != IDLE);
  assign debug_state  = state;

  logic        is_div;
  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic        start_neg;
  logic [31:0] start_mag_a;
  logic [31:0] start_mag_b;
  logic        div_zero;
  logic        overflow;
  logic [31:0] special_result;

  always_comb begin
    is_div      = funct3[2];
    a_signed    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed    = is_div ? ~funct3[0] : ~funct3[1];
    a_neg       = a_signed & rs1[31];
    b_neg       = b_signed & rs2[31];
    // Remainder follows the dividend; everything else follows the operand signs.
    start_neg   = (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg);
    start_mag_a = a_neg ? (32'd0 - rs1) : rs1;
    start_mag_b = b_neg ? (32'd0 - rs2) : rs2;
    div_zero    = is_div & (rs2 == 32'd0);
    overflow    = is_div & ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    if (div_zero) special_result = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else          special_result = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [32:0] sum;

  // Multiply: {hi,lo} holds {partial product, remaining multiplier bits}.
  // Divide:   {hi,lo} holds {partial remainder, dividend/quotient bits}.
  always_comb begin
    hi_n    = hi;
    lo_n    = lo;
    shifted = '0;
    diff    = '0;
    sum     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op[2]) begin
        shifted = {hi_n, lo_n[31]};
        diff    = shifted - {1'b0, mag_b};
        lo_n    = {lo_n[30:0], ~diff[32]};
        hi_n    = diff[32] ? shifted[31:0] : diff[31:0];
      end else begin
        sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, mag_a} : 33'd0);
        lo_n = {sum[0], lo_n[31:1]};
        hi_n = sum[32:1];
      end
    end
  end

  logic [63:0] prod_fin;
  logic [31:0] div_val;
  logic [31:0] div_fin;
  logic [31:0] final_result;

  always_comb begin
    prod_fin = neg ? (64'd0 - {hi_n, lo_n}) : {hi_n, lo_n};
    div_val  = op[1] ? hi_n : lo_n;
    div_fin  = neg ? (32'd0 - div_val) : div_val;
    if (op[2])                final_result = div_fin;
    else if (op[1:0] == 2'b00) final_result = prod_fin[31:0];
    else                      final_result = prod_fin[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      op          <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      hi          <= '0;
      lo          <= '0;
      neg         <= 1'b0;
      result      <= '0;
      resultValid <= 1'b0;
    end else begin
      resultValid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op <= funct3;
              if (div_zero | overflow) begin
                result      <= special_result;
                resultValid <= 1'b1;
                state       <= DONE;
              end else begin
                mag_a <= start_mag_a;
                mag_b <= start_mag_b;
                neg   <= start_neg;
                hi    <= '0;
                lo    <= is_div ? start_mag_a : start_mag_b;
                count <= CW'(N);
                state <= CALC;
              end
            end
          end
          CALC: begin
            hi    <= hi_n;
            lo    <= lo_n;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              result      <= final_result;
              resultValid <= 1'b1;
              state       <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
